// File: rtl/dac_spi_pkg.sv
// ---------------------------------------------------------------------------
// dac_spi_pkg
// Shared types and constants for the serial DAC transmitter:
//   state_e     - transmitter FSM states
//   FRAME_W     - width of one SPI write frame (16 bits)
//   TICKS       - divider ticks per frame (two per SCK period, 16 bits)
//   BIT_*       - command-bit positions inside the frame word
//   make_frame  - builds the frame word for a 10-bit sample
// ---------------------------------------------------------------------------
package dac_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CSH,
        ST_LDAC
    } state_e;

    localparam int DATA_W     = 10;
    localparam int FRAME_W    = 16;
    localparam int TICKS      = 32;
    localparam int TICK_CNT_W = $clog2(TICKS);

    localparam int BIT_AB     = 15;  // 0 selects DAC A
    localparam int BIT_BUF    = 14;  // VREF buffer enable
    localparam int BIT_GA_N   = 13;  // 1 = gain x1
    localparam int BIT_SHDN_N = 12;  // 1 = output active
    localparam int DATA_LSB   = 2;   // data occupies [11:2], [1:0] are don't-care zeros

    function automatic logic [FRAME_W-1:0] make_frame(input logic [DATA_W-1:0] data,
                                                      input logic              buf_en,
                                                      input logic              ga_n);
        logic [FRAME_W-1:0] w;
        w                       = '0;
        w[BIT_AB]               = 1'b0;
        w[BIT_BUF]              = buf_en;
        w[BIT_GA_N]             = ga_n;
        w[BIT_SHDN_N]           = 1'b1;
        w[DATA_LSB +: DATA_W]   = data;
        return w;
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// ---------------------------------------------------------------------------
// dac_spi_tx_if
// Bundles the sample-side handshake and the SPI/LDAC pins of dac_spi_tx.
//   data_in, load          - sample and one-cycle strobe from the producer
//   busy, overrun          - transmitter status
//   dac_cs, dac_sck,
//   dac_sdi, dac_ld        - DAC pins (CS and LDAC active-low, SPI mode 0)
// master: the sample producer / board side.  slave: the transmitter.
// ---------------------------------------------------------------------------
interface dac_spi_tx_if;
    import dac_spi_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              busy;
    logic              overrun;
    logic              dac_cs;
    logic              dac_sck;
    logic              dac_sdi;
    logic              dac_ld;

    modport master (
        output data_in, load,
        input  busy, overrun, dac_cs, dac_sck, dac_sdi, dac_ld
    );

    modport slave (
        input  data_in, load,
        output busy, overrun, dac_cs, dac_sck, dac_sdi, dac_ld
    );

endinterface

// File: rtl/spi_tick_gen.sv
// ---------------------------------------------------------------------------
// spi_tick_gen
// Divider producing a one-cycle tick every CLK_DIV enabled cycles.
//   sysclk  - system clock
//   rst_n   - synchronous active-low reset
//   clear   - restart the count at 0 (frame start, aligns tick phase to load)
//   enable  - count only while enabled
//   tick    - high during the last cycle of each CLK_DIV period
// ---------------------------------------------------------------------------
module spi_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // tick must not depend on clear: the parent derives clear from tick.
    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dac_spi_tx.sv
// ---------------------------------------------------------------------------
// dac_spi_tx
// Serial DAC transmitter: shifts each 10-bit sample as a 16-bit write frame
// to an MCP4911-class DAC, then pulses LDAC. A one-entry holding register
// absorbs a sample arriving mid-frame.
//   sysclk, rst_n  - clock, synchronous active-low reset
//   bus (slave)    - data_in/load in; busy/overrun/dac_cs/dac_sck/dac_sdi/dac_ld out
// Parameters: CLK_DIV (sysclk cycles per SCK half-period, >= 2),
//             DAC_BUF, DAC_GA_N (frame command bits).
// ---------------------------------------------------------------------------
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int   CLK_DIV  = 25,
    parameter logic DAC_BUF  = 1'b0,
    parameter logic DAC_GA_N = 1'b1
) (
    input  logic         sysclk,
    input  logic         rst_n,
    dac_spi_tx_if.slave  bus
);

    state_e                  state_q, state_d;
    logic [TICK_CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [FRAME_W-2:0]      shreg_q, shreg_d;     // bits still to send after dac_sdi
    logic [DATA_W-1:0]       hold_q, hold_d;
    logic                    hold_vld_q, hold_vld_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic                    cs_q, cs_d;
    logic                    sck_q, sck_d;
    logic                    sdi_q, sdi_d;
    logic                    ld_q, ld_d;

    logic                    tick;
    logic                    start;
    logic                    final_ldac;
    logic [DATA_W-1:0]       start_data;
    logic [FRAME_W-1:0]      frame;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .clear  (start),
        .enable (state_q != ST_IDLE),
        .tick   (tick)
    );

    assign final_ldac = (state_q == ST_LDAC) && tick;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        shreg_d    = shreg_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        sdi_d      = sdi_q;
        ld_d       = ld_q;
        start      = 1'b0;
        start_data = bus.data_in;
        frame      = '0;

        // Mid-frame load goes to the holding register; a valid entry is lost.
        if (bus.load && (state_q != ST_IDLE) && !final_ldac) begin
            hold_d     = bus.data_in;
            hold_vld_d = 1'b1;
            if (hold_vld_q) overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.load) start = 1'b1;
            end
            ST_SHIFT: begin
                if (tick) begin
                    sck_d      = ~sck_q;
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (sck_q) begin
                        // Falling SCK edge: present the next bit.
                        sdi_d   = shreg_q[FRAME_W-2];
                        shreg_d = {shreg_q[FRAME_W-3:0], 1'b0};
                    end
                    if (tick_cnt_q == TICK_CNT_W'(TICKS - 1)) begin
                        state_d    = ST_CSH;
                        cs_d       = 1'b1;
                        tick_cnt_d = '0;
                    end
                end
            end
            ST_CSH: begin
                if (tick) begin
                    state_d = ST_LDAC;
                    ld_d    = 1'b0;
                end
            end
            ST_LDAC: begin
                if (tick) begin
                    ld_d = 1'b1;
                    if (bus.load) begin
                        // Fresh sample wins; a held one is dropped.
                        start = 1'b1;
                        if (hold_vld_q) begin
                            hold_vld_d = 1'b0;
                            overrun_d  = 1'b1;
                        end
                    end else if (hold_vld_q) begin
                        start      = 1'b1;
                        start_data = hold_q;
                        hold_vld_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            frame      = make_frame(start_data, DAC_BUF, DAC_GA_N);
            state_d    = ST_SHIFT;
            tick_cnt_d = '0;
            shreg_d    = frame[FRAME_W-2:0];
            sdi_d      = frame[FRAME_W-1];
            cs_d       = 1'b0;
            sck_d      = 1'b0;
            busy_d     = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            shreg_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            sdi_q      <= 1'b0;
            ld_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            shreg_q    <= shreg_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            sdi_q      <= sdi_d;
            ld_q       <= ld_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
    assign bus.dac_cs  = cs_q;
    assign bus.dac_sck = sck_q;
    assign bus.dac_sdi = sdi_q;
    assign bus.dac_ld  = ld_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// ---------------------------------------------------------------------------
// tb_dac_spi_tx
// Directed bench for dac_spi_tx with CLK_DIV=4 and default command bits.
// Cycle n is the posedge numbered from the edge that samples the first load;
// outputs of cycle n are observed on the following negedge, and inputs for
// edge n+1 are driven right after that observation.
// ---------------------------------------------------------------------------
module tb_dac_spi_tx;

    localparam int CLK_DIV = 4;

    logic sysclk;
    logic rst_n;

    dac_spi_tx_if bus();

    dac_spi_tx #(
        .CLK_DIV  (CLK_DIV),
        .DAC_BUF  (1'b0),
        .DAC_GA_N (1'b1)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Load schedule for run_window: cycle numbers and data.
    int         ld_cyc[$];
    logic [9:0] ld_dat[$];

    // Observations recorded by run_window.
    int          frame_cnt;
    int          f_start [4];
    logic [15:0] f_word  [4];
    int          f_rises [4];
    int          f_cs_len[4];
    int          ld_first;
    int          ld_low_total;
    int          ld_pulses;
    int          busy_fall;
    int          sdi_bad;
    int          ovr_first;
    logic        ovr_last;

    task automatic drive_for(input int n);
        bus.load = 1'b0;
        foreach (ld_cyc[i]) begin
            if (ld_cyc[i] == n) begin
                bus.load    = 1'b1;
                bus.data_in = ld_dat[i];
            end
        end
    endtask

    task automatic run_window(input int ncyc);
        logic p_cs, p_sck, p_sdi, p_ld;
        int   fi;
        fi           = -1;
        frame_cnt    = 0;
        ld_first     = -1;
        ld_low_total = 0;
        ld_pulses    = 0;
        busy_fall    = -1;
        sdi_bad      = 0;
        ovr_first    = -1;
        ovr_last     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f_start[i]  = -1;
            f_word[i]   = '0;
            f_rises[i]  = 0;
            f_cs_len[i] = 0;
        end
        @(negedge sysclk);
        p_cs  = bus.dac_cs;
        p_sck = bus.dac_sck;
        p_sdi = bus.dac_sdi;
        p_ld  = bus.dac_ld;
        drive_for(0);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge sysclk);
            if (bus.dac_cs === 1'b0 && p_cs === 1'b1) begin
                fi = frame_cnt;
                if (frame_cnt < 4) f_start[frame_cnt] = c;
                frame_cnt++;
            end
            if (fi >= 0 && fi < 4) begin
                if (bus.dac_cs === 1'b0) f_cs_len[fi]++;
                if (bus.dac_sck === 1'b1 && p_sck === 1'b0) begin
                    f_word[fi] = {f_word[fi][14:0], bus.dac_sdi};
                    f_rises[fi]++;
                    if (bus.dac_sdi !== p_sdi) sdi_bad++;
                end
            end
            if (bus.dac_ld === 1'b0) begin
                ld_low_total++;
                if (ld_first < 0) ld_first = c;
                if (p_ld === 1'b1) ld_pulses++;
            end
            if (bus.busy === 1'b0 && busy_fall < 0) busy_fall = c;
            if (bus.overrun === 1'b1 && ovr_first < 0) ovr_first = c;
            ovr_last = bus.overrun;
            p_cs  = bus.dac_cs;
            p_sck = bus.dac_sck;
            p_sdi = bus.dac_sdi;
            p_ld  = bus.dac_ld;
            drive_for(c + 1);
        end
        bus.load = 1'b0;
        ld_cyc.delete();
        ld_dat.delete();
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        bus.load = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst_n       = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = '0;
        repeat (3) @(negedge sysclk);
        obs = {bus.busy, bus.overrun, bus.dac_cs, bus.dac_sck, bus.dac_sdi, bus.dac_ld};
        total_cnt++;
        if (obs !== 6'b001001)
            $display("FAIL reset_outputs: {busy,ovr,cs,sck,sdi,ld} got %b want 001001", obs);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        ld_cyc.push_back(0); ld_dat.push_back(10'h200);
        run_window(140);
        total_cnt++;
        if (f_word[0] !== 16'h3800) $display("FAIL single_word: got %h want 3800", f_word[0]);
        else pass_cnt++;
        total_cnt++;
        if (f_cs_len[0] !== 128) $display("FAIL single_cs_len: got %0d want 128", f_cs_len[0]);
        else pass_cnt++;
        total_cnt++;
        if (ld_first !== 132 || ld_low_total !== 4 || ld_pulses !== 1)
            $display("FAIL single_ldac: first %0d len %0d pulses %0d want 132 4 1",
                     ld_first, ld_low_total, ld_pulses);
        else pass_cnt++;
        total_cnt++;
        if (busy_fall !== 136) $display("FAIL single_busy_fall: got %0d want 136", busy_fall);
        else pass_cnt++;
    endtask

    task automatic test_patterns();
        logic [9:0]  dat [2];
        logic [15:0] exp_w [2];
        dat[0] = 10'h3FF; exp_w[0] = 16'h3FFC;
        dat[1] = 10'h000; exp_w[1] = 16'h3000;
        for (int i = 0; i < 2; i++) begin
            ld_cyc.push_back(0); ld_dat.push_back(dat[i]);
            run_window(140);
            total_cnt++;
            if (f_word[0] !== exp_w[i])
                $display("FAIL pattern_word[%0d]: got %h want %h", i, f_word[0], exp_w[i]);
            else pass_cnt++;
            total_cnt++;
            if (f_rises[0] !== 16)
                $display("FAIL pattern_sck_rises[%0d]: got %0d want 16", i, f_rises[0]);
            else pass_cnt++;
            total_cnt++;
            if (sdi_bad !== 0)
                $display("FAIL pattern_sdi_stable[%0d]: %0d unstable bits want 0", i, sdi_bad);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        ld_cyc.push_back(0);  ld_dat.push_back(10'h155);
        ld_cyc.push_back(40); ld_dat.push_back(10'h0AA);
        run_window(280);
        total_cnt++;
        if (frame_cnt !== 2 || f_start[1] !== 136)
            $display("FAIL b2b_frames: count %0d start2 %0d want 2 136", frame_cnt, f_start[1]);
        else pass_cnt++;
        total_cnt++;
        if (f_word[0] !== 16'h3554 || f_word[1] !== 16'h32A8)
            $display("FAIL b2b_words: got %h %h want 3554 32a8", f_word[0], f_word[1]);
        else pass_cnt++;
        total_cnt++;
        if (busy_fall !== 272) $display("FAIL b2b_busy_fall: got %0d want 272", busy_fall);
        else pass_cnt++;
        total_cnt++;
        if (ovr_first !== -1) $display("FAIL b2b_overrun: set at %0d want never", ovr_first);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        apply_reset();
        ld_cyc.push_back(0);  ld_dat.push_back(10'h001);
        ld_cyc.push_back(20); ld_dat.push_back(10'h002);
        ld_cyc.push_back(40); ld_dat.push_back(10'h003);
        run_window(280);
        total_cnt++;
        if (frame_cnt !== 2 || f_word[0] !== 16'h3004 || f_word[1] !== 16'h300C)
            $display("FAIL ovr_frames: count %0d words %h %h want 2 3004 300c",
                     frame_cnt, f_word[0], f_word[1]);
        else pass_cnt++;
        total_cnt++;
        if (ovr_first !== 40 || ovr_last !== 1'b1)
            $display("FAIL ovr_flag: first %0d last %b want 40 1", ovr_first, ovr_last);
        else pass_cnt++;
    endtask

    task automatic test_final_ldac_load();
        apply_reset();
        ld_cyc.push_back(0);   ld_dat.push_back(10'h001);
        ld_cyc.push_back(20);  ld_dat.push_back(10'h055);
        ld_cyc.push_back(136); ld_dat.push_back(10'h2AA);
        run_window(280);
        total_cnt++;
        if (frame_cnt !== 2 || f_start[1] !== 136 || f_word[1] !== 16'h3AA8)
            $display("FAIL final_ldac_frame: count %0d start2 %0d word %h want 2 136 3aa8",
                     frame_cnt, f_start[1], f_word[1]);
        else pass_cnt++;
        total_cnt++;
        if (ovr_first !== 136) $display("FAIL final_ldac_overrun: first %0d want 136", ovr_first);
        else pass_cnt++;
        total_cnt++;
        if (busy_fall !== 272) $display("FAIL final_ldac_busy: got %0d want 272", busy_fall);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [3:0] obs;
        int         ld_seen;
        int         quiet_bad;
        apply_reset();
        ld_seen   = 0;
        quiet_bad = 0;
        @(negedge sysclk);
        bus.load    = 1'b1;
        bus.data_in = 10'h3FF;
        for (int c = 0; c < 60; c++) begin
            @(negedge sysclk);
            if (bus.dac_ld !== 1'b1) ld_seen++;
            bus.load = 1'b0;
            if (c == 29) begin
                bus.load    = 1'b1;
                bus.data_in = 10'h111;
            end
            if (c == 59) rst_n = 1'b0;
        end
        @(negedge sysclk);
        obs = {bus.dac_cs, bus.dac_sck, bus.dac_ld, bus.busy};
        total_cnt++;
        if (obs !== 4'b1010)
            $display("FAIL midreset_outputs: {cs,sck,ld,busy} got %b want 1010", obs);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge sysclk);
            if (bus.dac_ld !== 1'b1) ld_seen++;
            if (bus.dac_cs !== 1'b1 || bus.busy !== 1'b0) quiet_bad++;
        end
        total_cnt++;
        if (ld_seen !== 0 || quiet_bad !== 0)
            $display("FAIL midreset_quiet: ld low %0d cycles, activity %0d cycles want 0 0",
                     ld_seen, quiet_bad);
        else pass_cnt++;
        ld_cyc.push_back(0); ld_dat.push_back(10'h2AA);
        run_window(140);
        total_cnt++;
        if (f_word[0] !== 16'h3AA8 || f_cs_len[0] !== 128 || busy_fall !== 136 || ld_first !== 132)
            $display("FAIL midreset_next_frame: word %h cs %0d busy_fall %0d ld %0d want 3aa8 128 136 132",
                     f_word[0], f_cs_len[0], busy_fall, ld_first);
        else pass_cnt++;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_single_frame();
        test_patterns();
        test_back_to_back();
        test_overrun();
        test_final_ldac_load();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
